dram_rd_return: RTL
===================

# dram_rd_return

Read-data return stage directly downstream of the DRAM controller. It samples the serial `dram_data_in` beats while the controller issues READ commands, packs them into L2-sized words tagged with the source bank, and queues them in a small FIFO. The FIFO presents words to the L2 side over a valid/ready handshake. It absorbs L2 back-pressure; overflow is flagged, never silently hidden.

## Interface
Parameters:
- `DATA_WIDTH`, default 1: bits per DRAM beat on `dram_data_in`.
- `WORD_WIDTH`, default 8: returned word width. Must be a multiple of `DATA_WIDTH`.
- `NUM_OF_BANKS`, default 8: bank count. The bank tag width is `$clog2(NUM_OF_BANKS)`.
- `FIFO_DEPTH`, default 4: return FIFO entries. Must be a power of 2, ≥2.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in, 1: clock. All state changes on the rising edge.
- `rst` in, 1: asynchronous active-high reset.
- `cmd` in, 2: controller command. 2'b00 NOP, 2'b01 READ, 2'b10 WRITE, 2'b11 REFRESH.
- `bank_rw` in, `$clog2(NUM_OF_BANKS)`: bank targeted by the current command.
- `dram_data_in` in, `DATA_WIDTH`: read beat. Valid in any cycle where `cmd`==READ.
- `rd_ready` in, 1: L2 accepts the head word.
- `rd_valid` out, 1: FIFO non-empty.
- `rd_word` out, `WORD_WIDTH`: head word.
- `rd_bank` out, `$clog2(NUM_OF_BANKS)`: bank tag of the head word.
- `busy` out, 1: a partial word is being assembled.
- `overflow` out, 1: sticky; a completed word was dropped.

## Operation
- `BEATS` = `WORD_WIDTH/DATA_WIDTH`. The beat counter width is `$clog2(BEATS)`, minimum 1. Shift register is `WORD_WIDTH` bits.
- Beats are packed LSB-first: beat k lands in `rd_word[k*DATA_WIDTH +: DATA_WIDTH]`.
- FSM states: IDLE, COLLECT.
- IDLE:
  - On `cmd`==READ: store beat 0, latch `bank_rw` as the word tag, set count=1, go to COLLECT.
  - If `BEATS`==1, the word completes on that same edge and the FSM stays in IDLE.
- COLLECT:
  - `cmd`==NOP: stall. Count and data are held.
  - `cmd`==READ with `bank_rw` equal to the latched tag: store the beat and increment count.
  - On the final beat (count==`BEATS`-1), push `{dram_data_in, partial}` with its tag and go to IDLE. Count wraps to 0.
  - `cmd`==READ with a different `bank_rw`: discard the partial word and restart as beat 0 of the new bank (tag updated, count=1). Stay in COLLECT.
  - `cmd`==WRITE or REFRESH: discard the partial word, count=0, go to IDLE.
- `busy` = (state==COLLECT).
- FIFO:
  - First-word fall-through. `rd_valid` = !empty. `rd_word`/`rd_bank` are combinational from the head entry.
  - Pop occurs when `rd_valid && rd_ready`. `rd_ready` while empty has no effect.
  - Push while full with no pop in the same cycle: the word is dropped, FIFO contents are unchanged, and `overflow` is set.
  - Push while full with a pop in the same cycle: the push succeeds and occupancy stays at `FIFO_DEPTH`.
  - Pointers wrap modulo `FIFO_DEPTH`. Occupancy is tracked with one extra bit.
- `overflow` clears only on `rst`.

## Timing
- Reset values: state IDLE, count 0, FIFO empty, `rd_valid`=0, `rd_word`=0, `rd_bank`=0, `busy`=0, `overflow`=0. Asserting `rst` mid-word or mid-drain discards everything immediately, without waiting for a clock edge.
- Latency: if the final beat is sampled at edge N and the FIFO was empty, `rd_valid`=1 and the word appear after edge N.
- Throughput: one word per `BEATS` READ cycles. Pop and push rates are both one per cycle.
- `rd_word`/`rd_bank` stay stable while `rd_valid && !rd_ready`.
- `overflow` rises the cycle after the dropped push edge.

## Configuration
- `DRAM_RD_PARITY_EN` defined:
  - Each FIFO entry stores an even-parity bit computed over the word at push time.
  - Adds output port `rd_parity` (1 bit, `^rd_word` of the head entry). Its reset value is 0.
- `DRAM_RD_PARITY_EN` undefined: no parity storage and no `rd_parity` port. All other behaviour is identical.

## Test plan
- Basic read: 8 READ cycles to bank 3 with bits 1,0,1,1,0,0,1,0, `rd_ready`=1. Expect `rd_valid` for exactly one cycle, `rd_word`=8'h4D, `rd_bank`=3. With `DRAM_RD_PARITY_EN`, `rd_parity`=0.
- Stall: same 8 beats with 3 NOP cycles after beat 4. Expect `rd_word`=8'h4D, `busy` high throughout the NOPs, and no early push.
- Abort and bank switch:
  - REFRESH after beat 5. Expect `busy`=0 the next cycle and no push.
  - READ to bank 2 after 3 beats of bank 5. Expect the following 8 bank-2 beats of all-ones to yield 8'hFF tagged 2, and nothing for bank 5.
- Back-pressure/overflow: `rd_ready`=0, push 5 words 8'h01..8'h05. Expect 4 queued, `overflow`=1. Then `rd_ready`=1: pops return 01,02,03,04 and `rd_valid` drops.
- Full with simultaneous pop: FIFO full, final beat of 8'hAA lands while `rd_ready`=1. Expect no overflow, occupancy stays 4, and 8'hAA is last out.
- Reset mid-operation: assert `rst` after beat 4 with 2 words queued. Expect all outputs back to reset values immediately; a fresh 8-beat read afterwards returns the correct word.

Source files
------------

// File: rtl/dram_rd_return.sv
// dram_rd_return: read-data return stage behind the DRAM controller.
// Packs serial READ beats (LSB-first) into bank-tagged words and queues them
// in a first-word fall-through FIFO with a valid/ready output handshake.
// A completed word that finds the FIFO full (and no pop that cycle) is dropped
// and flags the sticky overflow output.
// Optional feature: define DRAM_RD_PARITY_EN to store an even-parity bit per
// FIFO entry and expose it on rd_parity.
module dram_rd_return #(
    parameter int DATA_WIDTH   = 1,
    parameter int WORD_WIDTH   = 8,
    parameter int NUM_OF_BANKS = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      cmd,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] bank_rw,
    input  logic [DATA_WIDTH-1:0]           dram_data_in,
    input  logic                            rd_ready,
    output logic                            rd_valid,
    output logic [WORD_WIDTH-1:0]           rd_word,
    output logic [$clog2(NUM_OF_BANKS)-1:0] rd_bank,
    output logic                            busy,
`ifdef DRAM_RD_PARITY_EN
    output logic                            overflow,
    output logic                            rd_parity
`else
    output logic                            overflow
`endif
);

    localparam int BEATS  = WORD_WIDTH / DATA_WIDTH;
    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [PTR_W:0]   FULL_OCC  = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_READ = 2'b01;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_COLLECT = 1'b1;

    // Assembler state
    logic                  state, state_nxt;
    logic [CNT_W-1:0]      count, count_nxt;
    logic [WORD_WIDTH-1:0] shreg, shreg_nxt;
    logic [BANK_W-1:0]     tag, tag_nxt;
    logic [WORD_WIDTH-1:0] merged;
    logic [WORD_WIDTH-1:0] fresh;
    logic                  push;

    // FIFO state
    logic [WORD_WIDTH-1:0] mem_word [FIFO_DEPTH];
    logic [BANK_W-1:0]     mem_bank [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        occ;
    logic                  empty, full, pop, push_ok;

    // Beat placement and assembler next-state decode
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        shreg_nxt = shreg;
        tag_nxt   = tag;
        push      = 1'b0;

        // merged is the partial word with the current beat in slot 'count';
        // in IDLE count is 0, so it also serves as the single-beat word.
        merged = shreg;
        merged[int'(count) * DATA_WIDTH +: DATA_WIDTH] = dram_data_in;
        fresh = '0;
        fresh[DATA_WIDTH-1:0] = dram_data_in;

        case (state)
            ST_IDLE: begin
                if (cmd == CMD_READ) begin
                    tag_nxt = bank_rw;
                    if (BEATS == 1) begin
                        push      = 1'b1;
                        count_nxt = '0;
                    end else begin
                        shreg_nxt = fresh;
                        count_nxt = CNT_W'(1);
                        state_nxt = ST_COLLECT;
                    end
                end
            end
            default: begin
                if (cmd == CMD_READ) begin
                    if (bank_rw != tag) begin
                        shreg_nxt = fresh;
                        tag_nxt   = bank_rw;
                        count_nxt = CNT_W'(1);
                    end else if (count == LAST_BEAT) begin
                        push      = 1'b1;
                        count_nxt = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        shreg_nxt = merged;
                        count_nxt = count + CNT_W'(1);
                    end
                end else if (cmd != CMD_NOP) begin
                    count_nxt = '0;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Assembler registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            shreg <= '0;
            tag   <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            shreg <= shreg_nxt;
            tag   <= tag_nxt;
        end
    end

    assign busy    = (state == ST_COLLECT);
    assign empty   = (occ == '0);
    assign full    = (occ == FULL_OCC);
    assign pop     = !empty && rd_ready;
    assign push_ok = push && (!full || pop);

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop);
            if (push && !push_ok)
                overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are only visible while non-empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_word[wr_ptr] <= merged;
            mem_bank[wr_ptr] <= bank_rw;
        end
    end

    assign rd_valid = !empty;
    assign rd_word  = empty ? '0 : mem_word[rd_ptr];
    assign rd_bank  = empty ? '0 : mem_bank[rd_ptr];

`ifdef DRAM_RD_PARITY_EN
    logic mem_par [FIFO_DEPTH];

    // Parity bit captured alongside each pushed word
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_par[wr_ptr] <= ^merged;
    end

    assign rd_parity = empty ? 1'b0 : mem_par[rd_ptr];
`endif

endmodule
